fifo_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one ready/valid sink, typically the write port of a fifo_1r1w, between num_req_p independent producers.
- Selects one requester per transfer and forwards its word through a single registered pipeline stage.
- Tags each forwarded word with the index of the requester it came from.
- Sits directly upstream of the shared FIFO; its output channel connects straight to the FIFO's data_i/valid_i/ready_o.

---
 rtl/fifo_rr_arbiter.sv | 94 +++++++++
 tb/tb_fifo_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter feeding one registered ready/valid stage; 1-cycle accept-to-valid_o latency.
// Backpressure: stage_rdy = ~valid_o | ready_i gates the single granted ready_o bit; a stall holds everything.
module fifo_rr_arbiter #(
  parameter int width_p = 8,
  parameter int num_req_p = 4,
  localparam int id_width_p = $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           valid_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           ready_o,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  output logic [id_width_p-1:0]          id_o,
  input  logic                           ready_i
);

  typedef logic [id_width_p-1:0] id_t;
  typedef logic [id_width_p:0]   cand_t;

  logic               valid_q, valid_d;
  logic [width_p-1:0] data_q, data_d;
  id_t                id_q, id_d;
  id_t                ptr_q, ptr_d;

  logic  stage_rdy;
  logic  gnt_found;
  id_t   gnt_idx;
  cand_t cand;
  logic  accept;

  assign stage_rdy = ~valid_q | ready_i;

  // Search from ptr upward with an explicit wrap so non-power-of-two counts work.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = {1'b0, ptr_q} + cand_t'(i);
      if (cand >= cand_t'(num_req_p)) begin
        cand = cand - cand_t'(num_req_p);
      end
      if (!gnt_found && valid_i[cand[id_width_p-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[id_width_p-1:0];
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (gnt_found && !reset_i) begin
      ready_o[gnt_idx] = stage_rdy;
    end
  end

  assign accept = |(valid_i & ready_o);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i[gnt_idx*width_p +: width_p];
      id_d    = gnt_idx;
      ptr_d   = (gnt_idx == id_t'(num_req_p-1)) ? '0 : gnt_idx + 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign id_o    = id_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (4 requesters, 8-bit data) with a depth-4 FIFO sink modelled inline.
module tb_fifo_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  valid_i;
  logic [31:0] data_i;
  logic [3:0]  ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [1:0]  id_o;
  logic        ready_i;

  int n_cmp = 0;
  int n_err = 0;
  int fifo_cnt;
  int pushes;
  logic [1:0] exp_push [4];

  localparam logic [31:0] DATA_DEF = {8'h13, 8'h12, 8'h11, 8'h10};

  fifo_rr_arbiter #(.width_p(8), .num_req_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .id_o    (id_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(v));
    chk({tag, ".data_o"},  32'(data_o),  32'(d));
    chk({tag, ".id_o"},    32'(id_o),    32'(id));
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = '0;
    data_i  = DATA_DEF;
    ready_i = 1'b0;
    #3;
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    chk("rst.ready_o", 32'(ready_o), 32'h0);
    valid_i = 4'b1111;
    #1;
    chk("rst_held.ready_o", 32'(ready_o), 32'h0);
    valid_i = '0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    chk("idle.valid_o", 32'(valid_o), 32'h0);
    chk("idle.ready_o", 32'(ready_o), 32'h0);

    // Full contention: grants rotate 0,1,2,3 twice.
    valid_i = 4'b1111;
    ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("rr%0d.ready_o", j), 32'(ready_o), 32'(4'b0001 << (j % 4)));
      tick();
      chk_out($sformatf("rr%0d", j), 1'b1, 8'(8'h10 + j % 4), 2'(j % 4));
    end

    // Backpressure after id 1.
    tick();
    chk_out("bp_pre0", 1'b1, 8'h10, 2'd0);
    tick();
    chk_out("bp_pre1", 1'b1, 8'h11, 2'd1);
    ready_i = 1'b0;
    #1;
    chk("bp.ready_o", 32'(ready_o), 32'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", j), 1'b1, 8'h11, 2'd1);
      chk($sformatf("bp_hold%0d.ready_o", j), 32'(ready_o), 32'h0);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_rel.ready_o", 32'(ready_o), 32'b0100);
    tick();
    chk_out("bp_rel", 1'b1, 8'h12, 2'd2);
    valid_i = '0;
    tick();
    chk_out("drain", 1'b0, 8'h12, 2'd2);

    // Single requester 2 (pointer sits at 3 here).
    valid_i = 4'b0100;
    data_i  = {8'h13, 8'hA5, 8'h11, 8'h10};
    #1;
    chk("single.ready_o", 32'(ready_o), 32'b0100);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);

    // Pointer skip: ptr=3, only 0 and 1 valid, then 3 joins.
    data_i  = DATA_DEF;
    valid_i = 4'b0011;
    #1;
    chk("skip0.ready_o", 32'(ready_o), 32'b0001);
    tick();
    chk_out("skip0", 1'b1, 8'h10, 2'd0);
    valid_i = 4'b1011;
    #1;
    chk("skip1.ready_o", 32'(ready_o), 32'b0010);
    tick();
    chk_out("skip1", 1'b1, 8'h11, 2'd1);
    chk("skip3.ready_o", 32'(ready_o), 32'b1000);
    tick();
    chk_out("skip3", 1'b1, 8'h13, 2'd3);
    chk("skip_wrap.ready_o", 32'(ready_o), 32'b0001);
    tick();
    chk_out("skip_wrap", 1'b1, 8'h10, 2'd0);
    valid_i = '0;
    tick();
    chk("skip_drain.valid_o", 32'(valid_o), 32'h0);

    // Depth-4 FIFO sink never read; pointer starts at 1.
    exp_push[0] = 2'd1; exp_push[1] = 2'd2; exp_push[2] = 2'd3; exp_push[3] = 2'd0;
    fifo_cnt = 0;
    pushes   = 0;
    valid_i  = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      ready_i = (fifo_cnt < 4);
      #1;
      if (valid_o && ready_i) begin
        chk($sformatf("fifo_push%0d.id_o", pushes), 32'(id_o), 32'(exp_push[pushes]));
        pushes++;
        fifo_cnt++;
      end
      tick();
    end
    chk("fifo.pushes", 32'(pushes), 32'd4);
    ready_i = (fifo_cnt < 4);
    #1;
    chk("fifo_full.ready_o", 32'(ready_o), 32'h0);
    chk_out("fifo_full", 1'b1, 8'h11, 2'd1);
    for (int j = 0; j < 2; j++) begin
      tick();
      chk($sformatf("fifo_stall%0d.ready_o", j), 32'(ready_o), 32'h0);
      chk_out($sformatf("fifo_stall%0d", j), 1'b1, 8'h11, 2'd1);
    end
    fifo_cnt--;
    ready_i = (fifo_cnt < 4);
    #1;
    chk("fifo_read.ready_o", 32'(ready_o), 32'b0100);

    // Asynchronous reset mid-cycle with a word in flight.
    #1;
    reset_i = 1'b1;
    #1;
    chk_out("arst", 1'b0, 8'h00, 2'd0);
    chk("arst.ready_o", 32'(ready_o), 32'h0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("post_rst.ready_o", 32'(ready_o), 32'b0001);
    tick();
    chk_out("post_rst", 1'b1, 8'h10, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
